// File: rtl/memory_access_stage_pkg.sv
// Shared MEM-stage types: FSM encoding, writeback beat fields and op-type codes.
// Op codes mirror the decode/execute encodings so traces line up across stages.
package memory_access_stage_pkg;

  localparam int RD_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } mem_state_t;

  typedef enum logic [3:0] {
    OP_ALU   = 4'b0000,
    OP_LOAD  = 4'b1000,
    OP_STORE = 4'b1001,
    OP_BAD   = 4'b1111
  } mem_op_t;

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic            we;
    logic            err;
  } wb_meta_t;

  // Load and store together is not a legal op; it is reported as an error.
  function automatic mem_op_t decode_op(input logic re, input logic we);
    mem_op_t op;
    case ({re, we})
      2'b00:   op = OP_ALU;
      2'b10:   op = OP_LOAD;
      2'b01:   op = OP_STORE;
      default: op = OP_BAD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/memory_access_stage_timeout.sv
// Bus-timeout cycle counter: cleared when a memory op is accepted, counts REQ/WAIT cycles.
// expired is high on the TIMEOUT-th counted cycle and the count holds there.
module mem_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt_q;

  assign expired = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/memory_access_stage.sv
// Pipeline MEM stage: one op per ex handshake, dmem req/gnt/rvalid access, one wb beat per op.
// ALU and error ops return in 1 cycle; memory ops stall execute until the beat is produced.
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [ADDR_W-1:0] ex_mem_addr,
  input  logic [DATA_W-1:0] ex_mem_wdata,
  input  logic              ex_mem_we,
  input  logic              ex_mem_re,
  input  logic [RD_W-1:0]   ex_rd,
  input  logic              ex_rd_we,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [RD_W-1:0]   wb_rd,
  output logic              wb_we,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_err
);

  mem_state_t state_q, state_d;

  logic              live_q;
  mem_op_t           op_q;
  logic [RD_W-1:0]   rd_q;
  logic              rd_we_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-3:0] waddr_q;
  logic [DATA_W-1:0] park_data_q;
  logic              park_err_q;

  mem_op_t           ex_op;
  logic              ex_err;
  logic              slot_free;
  logic              accept;
  logic              cnt_clear;
  logic              cnt_en;
  logic              tmo_expired;
  logic              fin;
  logic [DATA_W-1:0] fin_data;
  logic              fin_err;
  logic              park_load;
  logic              wb_load;
  wb_meta_t          wb_meta_d;
  logic [DATA_W-1:0] wb_data_d;

  assign ex_op  = decode_op(ex_mem_re, ex_mem_we);
  assign ex_err = (ex_op == OP_BAD) ||
                  (((ex_op == OP_LOAD) || (ex_op == OP_STORE)) && (ex_mem_addr[1:0] != 2'b00));

  // live_q keeps ex_ready low while reset is asserted and for the reset-release edge.
  assign slot_free = !wb_valid || wb_ready;
  assign ex_ready  = live_q && (state_q == ST_IDLE) && slot_free;
  assign accept    = ex_valid && ex_ready;

  assign dmem_req   = (state_q == ST_REQ);
  assign dmem_we    = (op_q == OP_STORE);
  assign dmem_addr  = {waddr_q, 2'b00};
  assign dmem_wdata = wdata_q;

  assign cnt_en = (state_q == ST_REQ) || (state_q == ST_WAIT);

  mem_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_clear = 1'b0;
    fin       = 1'b0;
    fin_data  = '0;
    fin_err   = 1'b0;
    park_load = 1'b0;
    wb_load   = 1'b0;
    wb_meta_d = '0;
    wb_data_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (ex_err) begin
            wb_load   = 1'b1;
            wb_meta_d = '{rd: ex_rd, we: 1'b0, err: 1'b1};
          end else if (ex_op == OP_ALU) begin
            wb_load   = 1'b1;
            wb_meta_d = '{rd: ex_rd, we: ex_rd_we, err: 1'b0};
            wb_data_d = ex_alu_result;
          end else begin
            state_d   = ST_REQ;
            cnt_clear = 1'b1;
          end
        end
      end
      ST_REQ: begin
        // A store completes on its grant; a load granted on the expiry cycle still times out.
        if (dmem_gnt && (op_q == OP_STORE)) begin
          fin      = 1'b1;
          fin_data = alu_q;
        end else if (tmo_expired) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else if (dmem_gnt) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (dmem_rvalid) begin
          fin      = 1'b1;
          fin_data = dmem_rdata;
        end else if (tmo_expired) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end
      end
      ST_RESP: begin
        if (slot_free) begin
          wb_load   = 1'b1;
          wb_meta_d = '{rd: rd_q, we: rd_we_q && !park_err_q, err: park_err_q};
          wb_data_d = park_data_q;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fin) begin
      if (slot_free) begin
        wb_load   = 1'b1;
        wb_meta_d = '{rd: rd_q, we: rd_we_q && !fin_err, err: fin_err};
        wb_data_d = fin_data;
        state_d   = ST_IDLE;
      end else begin
        park_load = 1'b1;
        state_d   = ST_RESP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_ALU;
      rd_q    <= '0;
      rd_we_q <= 1'b0;
      alu_q   <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
    end else if (accept) begin
      op_q    <= ex_op;
      rd_q    <= ex_rd;
      rd_we_q <= ex_rd_we;
      alu_q   <= ex_alu_result;
      wdata_q <= ex_mem_wdata;
      waddr_q <= ex_mem_addr[ADDR_W-1:2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      park_data_q <= '0;
      park_err_q  <= 1'b0;
    end else if (park_load) begin
      park_data_q <= fin_data;
      park_err_q  <= fin_err;
    end
  end

  // A new beat may replace the old one in the cycle it is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_we    <= 1'b0;
      wb_data  <= '0;
      wb_err   <= 1'b0;
    end else if (wb_load) begin
      wb_valid <= 1'b1;
      wb_rd    <= wb_meta_d.rd;
      wb_we    <= wb_meta_d.we;
      wb_data  <= wb_data_d;
      wb_err   <= wb_meta_d.err;
    end else if (wb_ready) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_we    <= 1'b0;
      wb_data  <= '0;
      wb_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench for memory_access_stage: directed scenarios then randomized ops,
// with a behavioural memory responder and a reference model of the writeback stream.
module tb_memory_access_stage;

  localparam int AW  = 20;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          clk;
  logic          rst_n;
  logic          ex_valid;
  logic          ex_ready;
  logic [DW-1:0] ex_alu_result;
  logic [AW-1:0] ex_mem_addr;
  logic [DW-1:0] ex_mem_wdata;
  logic          ex_mem_we;
  logic          ex_mem_re;
  logic [4:0]    ex_rd;
  logic          ex_rd_we;
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_gnt;
  logic          dmem_rvalid;
  logic [DW-1:0] dmem_rdata;
  logic          wb_valid;
  logic          wb_ready;
  logic [4:0]    wb_rd;
  logic          wb_we;
  logic [DW-1:0] wb_data;
  logic          wb_err;

  memory_access_stage #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_alu_result (ex_alu_result),
    .ex_mem_addr   (ex_mem_addr),
    .ex_mem_wdata  (ex_mem_wdata),
    .ex_mem_we     (ex_mem_we),
    .ex_mem_re     (ex_mem_re),
    .ex_rd         (ex_rd),
    .ex_rd_we      (ex_rd_we),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_gnt      (dmem_gnt),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_rd         (wb_rd),
    .wb_we         (wb_we),
    .wb_data       (wb_data),
    .wb_err        (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
    logic        err;
    int          beat_cyc;
  } exp_t;

  typedef struct {
    logic [19:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          g;
    int          rv;
    bit          never_gnt;
    bit          never_rv;
  } mode_t;

  exp_t        exp_q[$];
  mode_t       mode_q[$];
  logic [31:0] model_mem[int];
  logic [31:0] dmem_arr[int];
  int          req_starts = 0;
  int          exp_req_starts = 0;
  bit          rdy_force = 1'b1;
  bit          rdy_val = 1'b1;

  initial begin
    wb_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      wb_ready = rdy_force ? rdy_val : ($urandom_range(0, 9) < 7);
    end
  end

  // Writeback monitor: pops the scoreboard on every consumed beat.
  initial begin
    logic        hold;
    logic [38:0] prev;
    exp_t        e;
    hold = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (wb_valid && hold)
          chk("wb_hold_stable", {wb_rd, wb_we, wb_err, wb_data}, prev);
        if (wb_valid && wb_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL wb_unexpected_beat: got rd=%0d data=0x%0h err=%0b, required no beat", wb_rd, wb_data, wb_err);
          end else begin
            e = exp_q.pop_front();
            chk("wb_rd", wb_rd, e.rd);
            chk("wb_we", wb_we, e.we);
            chk("wb_data", wb_data, e.data);
            chk("wb_err", wb_err, e.err);
            if (e.beat_cyc >= 0) chk("wb_latency", cyc, e.beat_cyc);
          end
        end
        hold = wb_valid && !wb_ready;
        prev = {wb_rd, wb_we, wb_err, wb_data};
      end
    end
  end

  // Memory responder. phase: 0 idle, 1 request pending, 2 read outstanding, 3 read never returns.
  initial begin
    int    phase;
    int    cnt;
    int    rcnt;
    bit    spur_ok;
    mode_t m;
    phase = 0;
    cnt = 0;
    rcnt = 0;
    m = '{20'h0, 1'b0, 32'h0, 0, 1, 1'b0, 1'b0};
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(negedge clk);
      dmem_gnt = 1'b0;
      dmem_rvalid = 1'b0;
      if (!rst_n) begin
        phase = 0;
      end else begin
        spur_ok = (phase == 0) || (phase == 1);
        if (phase == 2) begin
          if (rcnt == m.rv) begin
            dmem_rvalid = 1'b1;
            dmem_rdata = dmem_arr.exists(int'(m.addr[19:2])) ? dmem_arr[int'(m.addr[19:2])] : 32'h0;
            phase = 0;
          end else begin
            rcnt++;
          end
        end else begin
          if ((phase == 0 || phase == 3) && dmem_req) begin
            req_starts++;
            if (mode_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL dmem_req_unexpected: got req at addr 0x%0h, required no request", dmem_addr);
              phase = 0;
            end else begin
              m = mode_q.pop_front();
              chk("dmem_addr", dmem_addr, {m.addr[19:2], 2'b00});
              chk("dmem_we", dmem_we, m.we);
              if (m.we) chk("dmem_wdata", dmem_wdata, m.wdata);
              cnt = 0;
              phase = 1;
            end
          end
          if (phase == 1) begin
            if (!dmem_req) begin
              chk("req_cycles_before_drop", cnt, TMO);
              phase = 0;
            end else begin
              if (cnt > 0) chk("dmem_req_stable", {dmem_we, dmem_addr, dmem_wdata & {32{dmem_we}}},
                               {m.we, m.addr[19:2], 2'b00, m.wdata & {32{m.we}}});
              if (!m.never_gnt && cnt == m.g) begin
                dmem_gnt = 1'b1;
                if (m.we) begin
                  dmem_arr[int'(m.addr[19:2])] = m.wdata;
                  phase = 0;
                end else begin
                  rcnt = 1;
                  phase = m.never_rv ? 3 : 2;
                end
              end
              cnt++;
            end
          end
        end
        if (spur_ok && phase != 2 && !dmem_rvalid && $urandom_range(0, 7) == 0) begin
          dmem_rvalid = 1'b1;
          dmem_rdata = $urandom;
        end
      end
    end
  end

  task automatic issue(input logic [31:0] alu, input logic [19:0] addr, input logic [31:0] wd,
                       input logic we, input logic re, input logic [4:0] rd, input logic rd_we,
                       input int g, input int rv, input bit ng, input bit nr, input bit want_ready);
    int    waited;
    bit    acc;
    exp_t  e;
    mode_t m;
    ex_alu_result = alu;
    ex_mem_addr = addr;
    ex_mem_wdata = wd;
    ex_mem_we = we;
    ex_mem_re = re;
    ex_rd = rd;
    ex_rd_we = rd_we;
    ex_valid = 1'b1;
    waited = 0;
    acc = 1'b0;
    while (!acc && waited < 300) begin
      @(negedge clk);
      if (waited == 0 && want_ready) chk("ex_ready_immediate", ex_ready, 1'b1);
      if (ex_ready) acc = 1'b1;
      else waited++;
    end
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: ex_ready stayed 0 for %0d cycles, required acceptance", waited);
    end else begin
      e.rd = rd;
      e.beat_cyc = (rdy_force && rdy_val) ? cyc + 1 : -1;
      if ((we || re) && (addr[1:0] != 2'b00 || (we && re))) begin
        e.we = 1'b0; e.data = 32'h0; e.err = 1'b1;
      end else if (we || re) begin
        exp_req_starts++;
        m = '{addr, we, wd, g, rv, ng, nr};
        mode_q.push_back(m);
        e.beat_cyc = -1;
        if (ng || (re && nr)) begin
          e.we = 1'b0; e.data = 32'h0; e.err = 1'b1;
        end else if (we) begin
          e.we = rd_we; e.data = alu; e.err = 1'b0;
          model_mem[int'(addr[19:2])] = wd;
        end else begin
          e.we = rd_we; e.err = 1'b0;
          e.data = model_mem.exists(int'(addr[19:2])) ? model_mem[int'(addr[19:2])] : 32'h0;
        end
      end else begin
        e.we = rd_we; e.data = alu; e.err = 1'b0;
      end
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ex_ready"}, ex_ready, 1'b0);
    chk({tag, "_dmem_req"}, dmem_req, 1'b0);
    chk({tag, "_dmem_we"}, dmem_we, 1'b0);
    chk({tag, "_dmem_addr"}, dmem_addr, 20'h0);
    chk({tag, "_dmem_wdata"}, dmem_wdata, 32'h0);
    chk({tag, "_wb_valid"}, wb_valid, 1'b0);
    chk({tag, "_wb_rd"}, wb_rd, 5'h0);
    chk({tag, "_wb_we"}, wb_we, 1'b0);
    chk({tag, "_wb_data"}, wb_data, 32'h0);
    chk({tag, "_wb_err"}, wb_err, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          seen;
    int          kind;
    logic [19:0] a;
    rst_n = 1'b0;
    ex_valid = 1'b0;
    ex_alu_result = '0;
    ex_mem_addr = '0;
    ex_mem_wdata = '0;
    ex_mem_we = 1'b0;
    ex_mem_re = 1'b0;
    ex_rd = '0;
    ex_rd_we = 1'b0;
    #2;
    check_all_zero("reset");
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ex_ready_after_reset", ex_ready, 1'b1);

    // Back-to-back ALU ops
    issue(32'h5, 20'h0, 32'h0, 1'b0, 1'b0, 5'd1, 1'b1, 0, 1, 1'b0, 1'b0, 1'b1);
    issue(32'h6, 20'h0, 32'h0, 1'b0, 1'b0, 5'd2, 1'b1, 0, 1, 1'b0, 1'b0, 1'b1);
    issue(32'h7, 20'h0, 32'h0, 1'b0, 1'b0, 5'd3, 1'b0, 0, 1, 1'b0, 1'b0, 1'b1);
    // Store with grant after 3 cycles, then loads
    issue(32'hA5, 20'h00104, 32'hDEADBEEF, 1'b1, 1'b0, 5'd4, 1'b1, 3, 1, 1'b0, 1'b0, 1'b1);
    issue(32'h0, 20'h00200, 32'h0, 1'b0, 1'b1, 5'd5, 1'b1, 0, 2, 1'b0, 1'b0, 1'b0);
    issue(32'h0, 20'h00104, 32'h0, 1'b0, 1'b1, 5'd6, 1'b1, 1, 3, 1'b0, 1'b0, 1'b0);
    // Misaligned load and load+store conflict
    issue(32'h0, 20'h00201, 32'h0, 1'b0, 1'b1, 5'd7, 1'b1, 0, 1, 1'b0, 1'b0, 1'b0);
    issue(32'h0, 20'h00204, 32'h1, 1'b1, 1'b1, 5'd8, 1'b1, 0, 1, 1'b0, 1'b0, 1'b0);
    // Grant never arrives, then an ALU op must be accepted
    issue(32'h0, 20'h00300, 32'h0, 1'b0, 1'b1, 5'd9, 1'b1, 0, 1, 1'b1, 1'b0, 1'b0);
    issue(32'h77, 20'h0, 32'h0, 1'b0, 1'b0, 5'd10, 1'b1, 0, 1, 1'b0, 1'b0, 1'b0);

    // Load completes while WB is stalled for 4 cycles
    rdy_val = 1'b0;
    dmem_arr[int'(20'h00200 >> 2)] = 32'h12345678;
    model_mem[int'(20'h00200 >> 2)] = 32'h12345678;
    issue(32'h0, 20'h00200, 32'h0, 1'b0, 1'b1, 5'd11, 1'b1, 1, 1, 1'b0, 1'b0, 1'b0);
    seen = 0;
    while (!wb_valid && seen < 50) begin
      @(negedge clk);
      seen++;
    end
    if (!wb_valid) begin
      tests++;
      fails++;
      $display("FAIL stall_beat_timeout: wb_valid=0 after %0d cycles, required 1", seen);
    end
    for (int k = 0; k < 4; k++) begin
      chk("ex_ready_while_wb_stalled", ex_ready, 1'b0);
      @(negedge clk);
    end
    rdy_val = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset asserted while a load waits for read data
    issue(32'h0, 20'h00108, 32'h0, 1'b0, 1'b1, 5'd12, 1'b1, 0, 1, 1'b0, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_wait_reset");
    exp_q.delete();
    mode_q.delete();
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic with random WB backpressure
    rdy_force = 1'b0;
    for (int n = 0; n < 250; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      kind = $urandom_range(0, 19);
      a = 20'h00400 + 20'($urandom_range(0, 7) << 2);
      if (kind < 8) begin
        issue($urandom, 20'($urandom), $urandom, 1'b0, 1'b0, 5'($urandom), 1'($urandom), 0, 1, 1'b0, 1'b0, 1'b0);
      end else if (kind < 13) begin
        issue(32'h0, a, 32'h0, 1'b0, 1'b1, 5'($urandom), 1'($urandom), $urandom_range(0, 4),
              $urandom_range(1, 4), ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0), 1'b0);
      end else if (kind < 17) begin
        issue($urandom, a, $urandom, 1'b1, 1'b0, 5'($urandom), 1'($urandom), $urandom_range(0, 4),
              1, ($urandom_range(0, 19) == 0), 1'b0, 1'b0);
      end else if (kind < 19) begin
        issue($urandom, a | 20'($urandom_range(1, 3)), $urandom, 1'($urandom), 1'b1,
              5'($urandom), 1'b1, 0, 1, 1'b0, 1'b0, 1'b0);
      end else begin
        issue($urandom, a, $urandom, 1'b1, 1'b1, 5'($urandom), 1'b1, 0, 1, 1'b0, 1'b0, 1'b0);
      end
    end

    seen = 0;
    while (exp_q.size() != 0 && seen < 200) begin
      @(negedge clk);
      seen++;
    end
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("mode_queue_drained", mode_q.size(), 0);
    chk("dmem_request_count", req_starts, exp_req_starts);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
